// File: rtl/count_scheduler.sv
// Round-robin scheduler that lets two clients share one 4-bit counter.
// Each run issues a synchronous clear, then len count-enables, then checks the fed-back value.
module count_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic [WIDTH-1:0] q,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, CHK} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] len_q;
  logic             last;
  logic             owner;
  logic             any_req;
  logic             winner;

  // On contention the client that was not served last wins.
  always_comb begin
    any_req = req0 | req1;
    winner  = (req0 && req1) ? ~last : req1;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = CLR;
      CLR:     next_state = (len_q != '0) ? RUN : CHK;
      RUN:     if (rem == WIDTH'(1)) next_state = CHK;
      CHK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Run bookkeeping: latch winner and length at grant, count down, verify at the end.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rem   <= '0;
      len_q <= '0;
      last  <= 1'b1;
      owner <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= winner;
            rem   <= winner ? len1 : len0;
            len_q <= winner ? len1 : len0;
          end
        end
        RUN: rem <= rem - WIDTH'(1);
        CHK: begin
          if (q != len_q) err <= 1'b1;
          last <= owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    busy    = 1'b0;
    case (state)
      CLR: begin
        cnt_clr = 1'b1;
        busy    = 1'b1;
        gnt0    = ~owner;
        gnt1    = owner;
      end
      RUN: begin
        cnt_en = 1'b1;
        busy   = 1'b1;
        gnt0   = ~owner;
        gnt1   = owner;
      end
      CHK: begin
        done0 = ~owner;
        done1 = owner;
        busy  = 1'b1;
        gnt0  = ~owner;
        gnt1  = owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_count_scheduler.sv
// Bench for count_scheduler: a counter model on the DUT controls plus a run-timeline
// reference model that predicts every output from grant time, length and client.
module tb_count_scheduler;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [3:0] len0 = '0;
  logic [3:0] len1 = '0;
  logic [3:0] q;
  logic       cnt_clr, cnt_en, gnt0, gnt1, done0, done1, busy, err;

  logic [3:0] cntr;
  logic [3:0] mask = 4'hF;

  int vectors = 0;
  int miscompares = 0;

  bit mActive;
  bit mClient;
  int mLen;
  int mOff;
  bit mLast;
  bit mErr;

  count_scheduler #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .req0(req0), .req1(req1),
    .len0(len0), .len1(len1), .q(q),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Ideal SynchCount, with an optional stuck-at-0 mask on its outputs.
  always @(posedge clk or posedge clear) begin
    if (clear) cntr <= '0;
    else if (cnt_clr) cntr <= '0;
    else if (cnt_en) cntr <= cntr + 4'd1;
  end
  assign q = cntr & mask;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 0;
    mClient = 0;
    mLen    = 0;
    mOff    = 0;
    mLast   = 1;
    mErr    = 0;
  endtask

  // Advance the run timeline by one clock edge; offset 1 is the grant cycle.
  task automatic modelEdge();
    if (clear) return;
    if (mActive) begin
      mOff++;
      if (mOff == mLen + 3) begin
        if ((mLen & int'(mask)) != mLen) mErr = 1;
        mLast   = mClient;
        mActive = 0;
      end
    end else if (req0 || req1) begin
      mClient = (req0 && req1) ? !mLast : req1;
      mLen    = mClient ? int'(len1) : int'(len0);
      mActive = 1;
      mOff    = 1;
    end
  endtask

  function automatic logic [7:0] expectedOut();
    logic b, g0, g1, c, e, d0, d1;
    b  = mActive;
    g0 = mActive && !mClient;
    g1 = mActive && mClient;
    c  = mActive && (mOff == 1);
    e  = mActive && (mOff >= 2) && (mOff <= mLen + 1);
    d0 = g0 && (mOff == mLen + 2);
    d1 = g1 && (mOff == mLen + 2);
    return {b, g1, g0, c, e, d1, d0, mErr};
  endfunction

  function automatic logic [7:0] dutOut();
    return {busy, gnt1, gnt0, cnt_clr, cnt_en, done1, done0, err};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
    modelEdge();
    checkOutput("outputs", 32'(dutOut()), 32'(expectedOut()));
    if (mActive && mOff == mLen + 2)
      checkOutput("q_at_done", 32'(q), 32'(mLen & int'(mask)));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input logic [3:0] l0, input logic [3:0] l1);
    req0 = r0;
    req1 = r1;
    len0 = l0;
    len1 = l1;
  endtask

  // Asserts clear between edges, checks the asynchronous effect, holds, then releases.
  task automatic pulseClear(input int holdEdges);
    #2;
    clear = 1'b1;
    #1;
    modelReset();
    checkOutput("async_clear", 32'(dutOut()), 32'(expectedOut()));
    runCycles(holdEdges);
    #2;
    clear = 1'b0;
  endtask

  initial begin
    modelReset();

    // Reset held with both requests high: nothing may be granted.
    applyStimulus(1, 1, 4'd3, 4'd2);
    #1;
    checkOutput("reset_state", 32'(dutOut()), 32'(expectedOut()));
    runCycles(3);
    #3;
    clear = 1'b0;

    // Contention: alternation 0,1,0,1 with len0=3, len1=2.
    runCycles(30);

    // Single run on client 0, len 5.
    pulseClear(1);
    applyStimulus(1, 0, 4'd5, 4'd0);
    stepCycle();
    applyStimulus(0, 0, 4'd9, 4'd9);
    runCycles(9);

    // len1 = 0 boundary.
    applyStimulus(0, 1, 4'd0, 4'd0);
    stepCycle();
    applyStimulus(0, 0, 4'd0, 4'd0);
    runCycles(4);

    // len0 = 15 boundary.
    applyStimulus(1, 0, 4'd15, 4'd0);
    stepCycle();
    applyStimulus(0, 0, 4'd0, 4'd0);
    runCycles(19);

    // Fault: q1 stuck at 0 with len0=2; err is sticky through later good runs.
    mask = 4'b1101;
    applyStimulus(1, 0, 4'd2, 4'd0);
    stepCycle();
    applyStimulus(0, 0, 4'd0, 4'd0);
    runCycles(5);
    mask = 4'hF;
    applyStimulus(1, 1, 4'd4, 4'd1);
    runCycles(16);
    applyStimulus(0, 0, 4'd0, 4'd0);
    runCycles(8);
    pulseClear(1);
    runCycles(2);

    // Abort a len=8 run in cycle 4, then a req1-only run proceeds normally.
    applyStimulus(1, 0, 4'd8, 4'd0);
    runCycles(4);
    applyStimulus(0, 1, 4'd0, 4'd3);
    pulseClear(2);
    runCycles(3);
    applyStimulus(0, 0, 4'd0, 4'd0);
    runCycles(6);

    // Randomized traffic with occasional faults and asynchronous clears.
    for (int i = 0; i < 2000; i++) begin
      stepCycle();
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      len0 = 4'($urandom_range(0, 15));
      len1 = 4'($urandom_range(0, 15));
      if (!mActive && $urandom_range(0, 40) == 0)
        mask = ($urandom_range(0, 1) == 0) ? 4'hF : ~(4'd1 << $urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) pulseClear(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
